ch375_uart_rx: RTL and testbench
================================

# ch375_uart_rx

Serial receiver for the CH375 USB host controller link. It takes the asynchronous `ch375_tx` line driven by the CH375, recovers 8N1 (optionally 9N1) frames at a fixed baud rate, and queues the received words in a small FIFO. The core's MMIO peripheral logic then pops words from the FIFO. It sits between the `ch375_tx` pin of `pcpu_main` and the CH375 bus-slave register file.

## Interface
Parameters:
- `CLK_FREQ`, 100000000: system clock in Hz.
- `BAUD`, 19200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame. Legal values are 8 and 9; bit 8 is the CH375 command/data flag.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line from CH375 (`ch375_tx`). Idle level is high.
- `rd` in 1: pop strobe, one word per cycle.
- `rdata` out 9: FIFO head (first-word fall-through). Bit 8 is 0 when `DATA_BITS`=8.
- `rvalid` out 1: FIFO non-empty.
- `count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `frame_err` out 1: sticky; set when a stop bit is sampled low.
- `overrun` out 1: sticky; set when a word is dropped because the FIFO is full.
- `err_clr` in 1: clears both sticky flags.

## Operation
- Decided: one clock; reset is asynchronous and active-high.
- `rx` passes through a 2-flop synchronizer. Reset value is 1 (idle).
- `DIV` = (CLK_FREQ + BAUD/2) / BAUD, which is 5208 at the defaults. `HALF` = DIV/2.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized high→low edge loads the counter and moves to START.
  - START: after HALF cycles, sample the line. If it is high, this was a glitch: return to IDLE and record nothing. If it is low, move to DATA.
  - DATA: every DIV cycles, sample one bit, LSB first, into the shift register. After `DATA_BITS` samples, move to STOP.
  - STOP: after DIV cycles, sample the line. If it is high, push the word and go to IDLE. If it is low, set `frame_err`, discard the word, and stay in STOP until the line reads high, then go to IDLE.
- FIFO push on a full FIFO: drop the word and set `overrun`. If `rd` is asserted in the same cycle, the pop frees a slot and the push is accepted.
- Pop when empty: no effect, pointers unchanged.
- `err_clr` has priority over a same-cycle set; the flag clears.
- Reset mid-frame returns the FSM to IDLE and empties the FIFO; the partial word is lost.

## Timing
- Reset values:
  - `rvalid`=0, `count`=0, `rdata`=0.
  - `frame_err`=0, `overrun`=0.
  - FSM in IDLE, counters 0.
- Sample instants are measured from the first cycle the synchronized line reads low:
  - start bit: HALF
  - data bit n: HALF + (n+1)·DIV
  - stop bit: HALF + (DATA_BITS+1)·DIV
- Input synchronizer latency is 2 cycles.
- `rvalid`, `count` and `rdata` update in the cycle after the stop sample.
- `rd` with `rvalid`=1 advances the head. The new `rdata` and `count` are visible on the next edge.
- Back-to-back frames are supported: a start edge may be detected in the first cycle after STOP returns to IDLE.
- Sampling tolerance: ±4% baud mismatch at 8 data bits.

## Structure
- Shared package `pcpu_periph_pkg`: `UART_DIV` function, the FSM state enum, and CH375 flag-bit constants.
- Sub-module `sync_fifo`, parameterized on width and depth: registered pointers with an extra wrap bit for full/empty detection, plus `count`. It is reusable for the transmit side.
- The top level contains the synchronizer, baud counter, FSM, shift register and flags.

## Test plan
- Reset held 100 ns, then a frame 0x55 (start 0, bits 1010 1010, stop 1) at 52083 ns/bit → `rvalid` rises about 9.5 bit times after the start edge, `rdata`=0x055, `count`=1, no flags set.
- A 2 µs low glitch on idle `rx` → no push, FSM back in IDLE, `rvalid` stays 0.
- Frame 0xA3 with the stop bit forced low → `frame_err`=1, `count` unchanged. After `rx` returns high, frame 0x01 is received correctly. `err_clr` pulse → `frame_err`=0.
- 17 back-to-back frames 0x00…0x10, no pops → `count`=16, `overrun`=1, and popping yields 0x00…0x0F in order.
- FIFO full and `rd` asserted in the stop-sample-plus-1 cycle → word accepted, `count` stays 16, `overrun` stays 0.
- `DATA_BITS`=9, frame with bit 8=1 and data 0x22 → `rdata`=0x122. Reset asserted mid-frame → `count`=0, `rvalid`=0, and the next frame is received correctly.

Source files
------------

// File: rtl/pcpu_periph_pkg.sv
// Shared definitions for the pcpu peripheral blocks: baud divisor helper,
// UART receiver state encoding and CH375 word layout.
package pcpu_periph_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // CH375 words are 9 bits wide; bit 8 distinguishes command from data.
  localparam int unsigned CH375_WORD_W   = 9;
  localparam int unsigned CH375_FLAG_BIT = 8;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned UART_DIV(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// registered head, occupancy, valid and full.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_valid;
  logic             r_full;

  logic             w_do_pop;
  logic             w_do_push;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // A push into a full FIFO is only accepted when a pop frees a slot.
  always_comb begin
    w_do_pop   = i_pop && r_valid;
    w_do_push  = i_push && (!r_full || w_do_pop);
    w_wr_nxt   = r_wr_ptr + PW'(w_do_push);
    w_rd_nxt   = r_rd_ptr + PW'(w_do_pop);
    w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    if (w_do_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
      w_head_nxt = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_wr_nxt - w_rd_nxt;
      r_valid  <= (w_wr_nxt != w_rd_nxt);
      r_full   <= ((w_wr_nxt ^ w_rd_nxt) == {1'b1, {AW{1'b0}}});
      if (w_do_push || w_do_pop) begin
        r_rdata <= w_head_nxt;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/ch375_uart_rx.sv
// CH375 link receiver: synchronizes the serial line, recovers 8N1/9N1 frames
// and queues received words in a FWFT FIFO with sticky error flags.
module ch375_uart_rx
  import pcpu_periph_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd,
  output logic [CH375_WORD_W-1:0]       rdata,
  output logic                          rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int unsigned DIV   = UART_DIV(CLK_FREQ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = 4;

  logic [1:0]              r_sync;
  logic                    r_prev;
  rx_state_e               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [BIT_W-1:0]        r_bit;
  logic [CH375_WORD_W-1:0] r_shift;
  logic                    r_stop_wait;
  logic                    r_frame_err;
  logic                    r_overrun;

  logic w_rx;
  logic w_fall;
  logic w_stop_sample;
  logic w_push;
  logic w_ferr_set;
  logic w_ovr_set;
  logic w_full;

  assign w_rx          = r_sync[1];
  assign w_fall        = r_prev && !w_rx;
  assign w_stop_sample = (r_state == RX_STOP) && !r_stop_wait && (r_cnt == '0);
  assign w_push        = w_stop_sample && w_rx;
  assign w_ferr_set    = w_stop_sample && !w_rx;
  assign w_ovr_set     = w_push && w_full && !rd;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= w_rx;
    end
  end

  // Frame FSM: counters are reloaded so each sample lands mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= CNT_W'(HALF - 1);
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            if (w_rx) begin
              r_state <= RX_IDLE;
            end else begin
              r_state <= RX_DATA;
              r_cnt   <= CNT_W'(DIV - 1);
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_shift                <= {1'b0, r_shift[CH375_WORD_W-1:1]};
            r_shift[DATA_BITS-1]   <= w_rx;
            r_cnt                  <= CNT_W'(DIV - 1);
            if (r_bit == BIT_W'(DATA_BITS - 1)) begin
              r_state <= RX_STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          // A low stop bit parks here until the line is idle again.
          if (r_stop_wait) begin
            if (w_rx) begin
              r_stop_wait <= 1'b0;
              r_state     <= RX_IDLE;
            end
          end else if (r_cnt == '0) begin
            if (w_rx) begin
              r_state <= RX_IDLE;
            end else begin
              r_stop_wait <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (err_clr) begin
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        if (w_ferr_set) r_frame_err <= 1'b1;
        if (w_ovr_set)  r_overrun   <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (CH375_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (rd),
    .o_rdata (rdata),
    .o_valid (rvalid),
    .o_full  (w_full),
    .o_count (count)
  );

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ch375_uart_rx.sv
// Scoreboard bench for ch375_uart_rx: an 8-bit and a 9-bit instance driven
// with bit-accurate frames at a reduced clock/baud ratio.
module tb_ch375_uart_rx;
  import pcpu_periph_pkg::*;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          DIV      = 16;
  localparam int          HALF     = 8;
  localparam int          DEPTH    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx8 = 1'b1, rd8 = 1'b0, clr8 = 1'b0;
  logic rx9 = 1'b1, rd9 = 1'b0, clr9 = 1'b0;
  logic [8:0] rdata8, rdata9;
  logic       rvalid8, rvalid9;
  logic [4:0] count8, count9;
  logic       ferr8, ferr9, ovr8, ovr9;

  always #5 clk = ~clk;

  ch375_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rd(rd8), .rdata(rdata8), .rvalid(rvalid8),
    .count(count8), .frame_err(ferr8), .overrun(ovr8), .err_clr(clr8));

  ch375_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .FIFO_DEPTH(DEPTH)) dut9 (
    .clk(clk), .rst(rst), .rx(rx9), .rd(rd9), .rdata(rdata9), .rvalid(rvalid9),
    .count(count9), .frame_err(ferr9), .overrun(ovr9), .err_clr(clr9));

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] q8[$];
  logic [8:0] q9[$];
  logic exp_ferr8 = 1'b0;
  logic exp_ovr8  = 1'b0;
  int rise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame bit-by-bit; optionally pulse rd8 in cycle rd_at and
  // report the first cycle in which rvalid is seen high.
  task automatic send_frame(input bit sel, input logic [8:0] w, input bit stop_ok,
                            input int rd_at, output int first_valid);
    int db;
    int nb;
    logic [10:0] fr;
    logic [8:0] head;
    db = sel ? 9 : 8;
    nb = db + 2;
    fr = '1;
    fr[0] = 1'b0;
    for (int k = 0; k < db; k++) fr[k+1] = w[k];
    fr[db+1] = stop_ok;
    first_valid = -1;
    for (int i = 0; i < nb * DIV; i++) begin
      @(posedge clk);
      #1;
      if (sel) rx9 = fr[i / DIV];
      else begin
        rx8 = fr[i / DIV];
        rd8 = (i == rd_at);
      end
      @(negedge clk);
      if (!sel && i == rd_at) begin
        head = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
        chk("rd_head", rdata8, head);
      end
      if (first_valid < 0 && (sel ? rvalid9 : rvalid8)) first_valid = i;
    end
    @(posedge clk);
    #1;
    rd8 = 1'b0;
    rx8 = 1'b1;
    rx9 = 1'b1;
    if (stop_ok) begin
      if (sel) q9.push_back(w);
      else if (q8.size() < DEPTH) q8.push_back(w);
      else exp_ovr8 = 1'b1;
    end else if (!sel) begin
      exp_ferr8 = 1'b1;
    end
  endtask

  task automatic pop_check(input bit sel);
    logic [8:0] exp;
    @(negedge clk);
    if (sel) begin
      exp = (q9.size() != 0) ? q9.pop_front() : 9'h1FF;
      chk("pop_valid9", rvalid9, 1);
      chk("pop_data9", rdata9, exp);
    end else begin
      exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
      chk("pop_valid8", rvalid8, 1);
      chk("pop_data8", rdata8, exp);
    end
    @(posedge clk);
    #1;
    if (sel) rd9 = 1'b1; else rd8 = 1'b1;
    @(posedge clk);
    #1;
    rd8 = 1'b0;
    rd9 = 1'b0;
  endtask

  task automatic check_state8(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, count8, q8.size());
    chk({tag, "_rvalid"}, rvalid8, q8.size() != 0);
    chk({tag, "_ferr"}, ferr8, exp_ferr8);
    chk({tag, "_ovr"}, ovr8, exp_ovr8);
  endtask

  task automatic clear8();
    @(posedge clk);
    #1 clr8 = 1'b1;
    @(posedge clk);
    #1 clr8 = 1'b0;
    exp_ferr8 = 1'b0;
    exp_ovr8  = 1'b0;
  endtask

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", rvalid8, 0);
    chk("rst_count", count8, 0);
    chk("rst_rdata", rdata8, 0);
    chk("rst_ferr", ferr8, 0);
    chk("rst_ovr", ovr8, 0);
    chk("rst_rvalid9", rvalid9, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * DIV);

    // First frame: latency from start-bit drive to rvalid
    send_frame(0, 9'h055, 1, -1, rise);
    chk("lat55", rise, 3 + HALF + 9 * DIV);
    check_state8("f55");
    chk("f55_data", rdata8, 9'h055);
    pop_check(0);

    // Short low glitch must not start a frame
    @(posedge clk);
    #1 rx8 = 1'b0;
    idle(3);
    rx8 = 1'b1;
    idle(2 * DIV);
    check_state8("glitch");

    // Low stop bit, then a good frame, then clear
    send_frame(0, 9'h0A3, 0, -1, rise);
    check_state8("ferr");
    idle(DIV);
    send_frame(0, 9'h001, 1, -1, rise);
    check_state8("f01");
    pop_check(0);
    clear8();
    check_state8("clr1");

    // Overfill: 17 back-to-back frames
    for (int k = 0; k < 17; k++) send_frame(0, 9'(k), 1, -1, rise);
    check_state8("ovr");
    for (int k = 0; k < 16; k++) pop_check(0);
    clear8();
    check_state8("clr2");

    // Full FIFO with a pop in the push cycle
    for (int k = 0; k < 16; k++) send_frame(0, 9'(8'h20 + k), 1, -1, rise);
    send_frame(0, 9'h030, 1, 2 + HALF + 9 * DIV, rise);
    check_state8("fullrd");
    for (int k = 0; k < 16; k++) pop_check(0);
    check_state8("drain");

    // 9-bit frame with the command flag set
    send_frame(1, 9'((1 << CH375_FLAG_BIT) | 9'h022), 1, -1, rise);
    chk("lat9", rise, 3 + HALF + 10 * DIV);
    @(negedge clk);
    chk("f9_count", count9, 1);
    chk("f9_data", rdata9, 9'h122);

    // Reset in the middle of a frame
    @(posedge clk);
    #1 rx9 = 1'b0;
    idle(3 * DIV);
    rst = 1'b1;
    rx9 = 1'b1;
    idle(5);
    @(negedge clk);
    chk("mid_count9", count9, 0);
    chk("mid_rvalid9", rvalid9, 0);
    chk("mid_rdata9", rdata9, 0);
    q9.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * DIV);
    send_frame(1, 9'h0AB, 1, -1, rise);
    pop_check(1);
    @(negedge clk);
    chk("end_count9", count9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
